// File: rtl/pe_array_search_pkg.sv
// Shared definitions for the full-search SAD engine.
//   - state_t : control FSM states
//   - clog2   : ceiling log2, usable in constant expressions
//   - sad_w_of / mv_w_of / lat_of : derived widths and pipeline latency
package pe_array_search_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_TB, SEARCH, DRAIN, DONE} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Wide enough for TB^2 * (2^PIX_W - 1), so the SAD can never overflow.
  function automatic int sad_w_of(input int tb_len, input int pix_w);
    return pix_w + 2 * clog2(tb_len);
  endfunction

  function automatic int mv_w_of(input int sw_len, input int tb_len);
    return clog2(sw_len - tb_len + 1);
  endfunction

  // One stage for the window array plus one per adder-tree level.
  function automatic int lat_of(input int tb_len);
    return 1 + clog2(tb_len * tb_len);
  endfunction

endpackage

// File: rtl/pe_array_search_if.sv
// Bus bundle of the SAD engine: template/window pixel streams (valid/ready),
// per-candidate result strobe, search status and best-match result.
//   master : pixel fetch side / bench (drives start, pixels, valids)
//   slave  : the engine (drives readies, candidate and best-match outputs)
interface pe_array_search_if #(
  parameter int TB_LENGTH = 8,
  parameter int SW_LENGTH = 32,
  parameter int PIX_W     = 8
);
  import pe_array_search_pkg::*;

  localparam int SAD_W = sad_w_of(TB_LENGTH, PIX_W);
  localparam int MV_W  = mv_w_of(SW_LENGTH, TB_LENGTH);

  logic             start;
  logic             tb_valid;
  logic             tb_ready;
  logic [PIX_W-1:0] pel_tb;
  logic             sw_valid;
  logic             sw_ready;
  logic [PIX_W-1:0] pel_sw;
  logic             cand_valid;
  logic [SAD_W-1:0] cand_sad;
  logic [MV_W-1:0]  cand_x;
  logic [MV_W-1:0]  cand_y;
  logic             busy;
  logic             done;
  logic [SAD_W-1:0] best_sad;
  logic [MV_W-1:0]  best_x;
  logic [MV_W-1:0]  best_y;

  modport master (
    output start, tb_valid, pel_tb, sw_valid, pel_sw,
    input  tb_ready, sw_ready, cand_valid, cand_sad, cand_x, cand_y,
           busy, done, best_sad, best_x, best_y
  );

  modport slave (
    input  start, tb_valid, pel_tb, sw_valid, pel_sw,
    output tb_ready, sw_ready, cand_valid, cand_sad, cand_x, cand_y,
           busy, done, best_sad, best_x, best_y
  );

endinterface

// File: rtl/pe_array_search_sad_min_tracker.sv
// Strict-minimum tracker over the candidate SAD stream.
//   clear      : arm for a new search (min <- all ones)
//   cand_*     : candidate strobe, SAD and position
//   latch      : copy the running minimum (including a candidate arriving in
//                the same cycle) onto best_*
//   best_*     : held result, cleared only by rst
module sad_min_tracker #(
  parameter int SAD_W = 14,
  parameter int MV_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             latch,
  input  logic             cand_valid,
  input  logic [SAD_W-1:0] cand_sad,
  input  logic [MV_W-1:0]  cand_x,
  input  logic [MV_W-1:0]  cand_y,
  output logic [SAD_W-1:0] best_sad,
  output logic [MV_W-1:0]  best_x,
  output logic [MV_W-1:0]  best_y
);

  logic [SAD_W-1:0] min_sad, min_sad_nxt;
  logic [MV_W-1:0]  min_x, min_x_nxt, min_y, min_y_nxt;

  // Strict compare: on a tie the earlier raster candidate is kept.
  always_comb begin
    min_sad_nxt = min_sad;
    min_x_nxt   = min_x;
    min_y_nxt   = min_y;
    if (cand_valid && (cand_sad < min_sad)) begin
      min_sad_nxt = cand_sad;
      min_x_nxt   = cand_x;
      min_y_nxt   = cand_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_sad  <= '0;
      min_x    <= '0;
      min_y    <= '0;
      best_sad <= '0;
      best_x   <= '0;
      best_y   <= '0;
    end else begin
      if (clear) begin
        min_sad <= '1;
        min_x   <= '0;
        min_y   <= '0;
      end else begin
        min_sad <= min_sad_nxt;
        min_x   <= min_x_nxt;
        min_y   <= min_y_nxt;
      end
      if (latch) begin
        best_sad <= min_sad_nxt;
        best_x   <= min_x_nxt;
        best_y   <= min_y_nxt;
      end
    end
  end

endmodule

// File: rtl/pe_array_search.sv
// Full-search SAD engine. Loads a TB x TB template, streams an SW x SW window
// in raster order through a TB x TB pixel array with (SW-TB)-deep line buffers,
// sums |tb - sw| with a fully registered adder tree, and reports every legal
// candidate plus the minimum-SAD motion vector.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pe_array_search_if slave (streams, candidates, status, result)
module pe_array_search
  import pe_array_search_pkg::*;
#(
  parameter int TB_LENGTH = 8,
  parameter int SW_LENGTH = 32,
  parameter int PIX_W     = 8
) (
  input logic              clk,
  input logic              rst,
  pe_array_search_if.slave bus
);

  localparam int SAD_W = sad_w_of(TB_LENGTH, PIX_W);
  localparam int MV_W  = mv_w_of(SW_LENGTH, TB_LENGTH);
  localparam int LAT   = lat_of(TB_LENGTH);
  localparam int NPIX  = TB_LENGTH * TB_LENGTH;
  localparam int LB_D  = SW_LENGTH - TB_LENGTH;
  localparam int TCW   = clog2(NPIX);
  localparam int SCW   = clog2(SW_LENGTH);
  localparam int DCW   = clog2(LAT);

  function automatic logic [SAD_W-1:0] absdiff(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    logic signed [PIX_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return SAD_W'(unsigned'(d));
  endfunction

  state_t         state, state_nxt;
  logic           tb_beat, sw_beat, adv, tb_last, sw_last, drain_last;
  logic [TCW-1:0] tb_cnt;
  logic [SCW-1:0] row, col;
  logic [DCW-1:0] drain_cnt;

  assign tb_beat    = bus.tb_valid && bus.tb_ready;
  assign sw_beat    = bus.sw_valid && bus.sw_ready;
  // The tree moves on window beats while searching and freely while draining.
  assign adv        = sw_beat || (state == DRAIN);
  assign tb_last    = tb_beat && (tb_cnt == TCW'(NPIX - 1));
  assign sw_last    = sw_beat && (row == SCW'(SW_LENGTH - 1)) && (col == SCW'(SW_LENGTH - 1));
  assign drain_last = (state == DRAIN) && (drain_cnt == DCW'(LAT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD_TB;
      LOAD_TB: if (tb_last)   state_nxt = SEARCH;
      SEARCH:  if (sw_last)   state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.tb_ready = 1'b0;
    bus.sw_ready = 1'b0;
    bus.done     = 1'b0;
    bus.busy     = (state != IDLE);
    case (state)
      LOAD_TB: bus.tb_ready = 1'b1;
      SEARCH:  bus.sw_ready = 1'b1;
      DONE:    bus.done     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (state == IDLE)) begin
      tb_cnt    <= '0;
      row       <= '0;
      col       <= '0;
      drain_cnt <= '0;
    end else begin
      if (tb_beat) tb_cnt <= tb_cnt + TCW'(1);
      if (sw_beat) begin
        if (col == SCW'(SW_LENGTH - 1)) begin
          col <= '0;
          row <= row + SCW'(1);
        end else begin
          col <= col + SCW'(1);
        end
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + DCW'(1);
    end
  end

  logic [PIX_W-1:0] tmpl [NPIX];

  always_ff @(posedge clk) begin
    if (tb_beat) tmpl[tb_cnt] <= bus.pel_tb;
  end

  // ---- stage p0: window array; win_p0[ty][tx] holds pixel (r-(TB-1)+ty, c-(TB-1)+tx)
  logic [PIX_W-1:0] win_p0 [TB_LENGTH][TB_LENGTH];
  logic [PIX_W-1:0] lbuf   [TB_LENGTH][LB_D];

  always_ff @(posedge clk) begin
    if (sw_beat) begin
      for (int ty = 0; ty < TB_LENGTH; ty++) begin
        for (int tx = 0; tx < TB_LENGTH - 1; tx++) win_p0[ty][tx] <= win_p0[ty][tx+1];
        for (int k = 0; k < LB_D - 1; k++) lbuf[ty][k] <= lbuf[ty][k+1];
        lbuf[ty][LB_D-1] <= win_p0[ty][0];
      end
      // Each row plus its line buffer delays the stream by exactly SW pixels.
      for (int ty = 0; ty < TB_LENGTH - 1; ty++) win_p0[ty][TB_LENGTH-1] <= lbuf[ty+1][0];
      win_p0[TB_LENGTH-1][TB_LENGTH-1] <= bus.pel_sw;
    end
  end

  logic             legal_in;
  logic [MV_W-1:0]  x_in, y_in;
  logic             vld_p [LAT-1];
  logic [MV_W-1:0]  x_p [LAT-1];
  logic [MV_W-1:0]  y_p [LAT-1];

  // Positions whose window would wrap a row or the top edge are masked here.
  assign legal_in = sw_beat && (row >= SCW'(TB_LENGTH - 1)) && (col >= SCW'(TB_LENGTH - 1));
  assign x_in     = MV_W'(col - SCW'(TB_LENGTH - 1));
  assign y_in     = MV_W'(row - SCW'(TB_LENGTH - 1));

  logic [SAD_W-1:0] leaf [NPIX];

  always_comb begin
    for (int i = 0; i < NPIX; i++)
      leaf[i] = absdiff(tmpl[i], win_p0[i / TB_LENGTH][i % TB_LENGTH]);
  end

  // ---- stages p1..p(LAT-2): heap-indexed tree, node k = child 2k + child 2k+1
  logic [SAD_W-1:0] sum_p [2:NPIX-1];

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 2; k < NPIX; k++) begin
        if (k >= NPIX / 2) sum_p[k] <= leaf[2*k - NPIX] + leaf[2*k + 1 - NPIX];
        else               sum_p[k] <= sum_p[2*k] + sum_p[2*k + 1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      x_p[0] <= x_in;
      y_p[0] <= y_in;
      for (int s = 1; s < LAT - 1; s++) begin
        x_p[s] <= x_p[s-1];
        y_p[s] <= y_p[s-1];
      end
    end
  end

  // ---- stage p(LAT-1): candidate output
  logic             cand_vld_p;
  logic [SAD_W-1:0] cand_sad_p;
  logic [MV_W-1:0]  cand_x_p, cand_y_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LAT - 1; s++) vld_p[s] <= 1'b0;
      cand_vld_p <= 1'b0;
    end else begin
      // Gated with adv so a stalled pipeline cannot repeat the strobe.
      cand_vld_p <= adv && vld_p[LAT-2];
      if (adv) begin
        vld_p[0] <= legal_in;
        for (int s = 1; s < LAT - 1; s++) vld_p[s] <= vld_p[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_sad_p <= '0;
      cand_x_p   <= '0;
      cand_y_p   <= '0;
    end else if (adv) begin
      cand_sad_p <= sum_p[2] + sum_p[3];
      cand_x_p   <= x_p[LAT-2];
      cand_y_p   <= y_p[LAT-2];
    end
  end

  assign bus.cand_valid = cand_vld_p;
  assign bus.cand_sad   = cand_sad_p;
  assign bus.cand_x     = cand_x_p;
  assign bus.cand_y     = cand_y_p;

  sad_min_tracker #(.SAD_W(SAD_W), .MV_W(MV_W)) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear      (tb_last),
    .latch      (drain_last),
    .cand_valid (cand_vld_p),
    .cand_sad   (cand_sad_p),
    .cand_x     (cand_x_p),
    .cand_y     (cand_y_p),
    .best_sad   (bus.best_sad),
    .best_x     (bus.best_x),
    .best_y     (bus.best_y)
  );

endmodule

// File: tb/tb_pe_array_search.sv
// Randomized bench for pe_array_search against a direct full-search SAD model.
module tb_pe_array_search;

  localparam int TBL = 8;
  localparam int SWL = 32;
  localparam int PW  = 8;
  localparam int NC  = SWL - TBL + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_array_search_if #(.TB_LENGTH(TBL), .SW_LENGTH(SWL), .PIX_W(PW)) bus ();

  pe_array_search #(.TB_LENGTH(TBL), .SW_LENGTH(SWL), .PIX_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int tbp [TBL*TBL];
  int swp [SWL*SWL];
  int exp_sad [NC*NC];
  int exp_best_sad, exp_best_x, exp_best_y;
  int got_q [$];
  int done_cnt = 0;
  int done_sad, done_x, done_y, done_busy;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (bus.cand_valid === 1'b1)
      got_q.push_back(int'(bus.cand_sad) * 65536 + int'(bus.cand_y) * 256 + int'(bus.cand_x));
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_sad  = int'(bus.best_sad);
      done_x    = int'(bus.best_x);
      done_y    = int'(bus.best_y);
      done_busy = int'(bus.busy);
    end
  end

  // Exhaustive search over every candidate offset, raster order, strict minimum.
  task automatic model_run();
    int s, d;
    exp_best_sad = 32'h7fffffff;
    exp_best_x   = 0;
    exp_best_y   = 0;
    for (int y = 0; y < NC; y++) begin
      for (int x = 0; x < NC; x++) begin
        s = 0;
        for (int j = 0; j < TBL; j++)
          for (int i = 0; i < TBL; i++) begin
            d = tbp[j*TBL + i] - swp[(y + j)*SWL + x + i];
            s += (d < 0) ? -d : d;
          end
        exp_sad[y*NC + x] = s;
        if (s < exp_best_sad) begin
          exp_best_sad = s;
          exp_best_x   = x;
          exp_best_y   = y;
        end
      end
    end
  endtask

  task automatic run_search(input string name, input int bubble, input int rst_beat);
    int idx, guard, base_done, want;
    logic beat;
    got_q.delete();
    base_done = done_cnt;
    model_run();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;

    idx = 0; guard = 0;
    while (idx < TBL*TBL && guard < 20000) begin
      bus.tb_valid = ($urandom_range(0, 99) >= bubble);
      bus.pel_tb   = PW'(tbp[idx]);
      beat = bus.tb_valid && bus.tb_ready;
      @(posedge clk); #1;
      if (beat) idx++;
      guard++;
    end
    bus.tb_valid = 1'b0;
    check_val({name, " tb_beats"}, idx, TBL*TBL);

    idx = 0; guard = 0;
    while (idx < SWL*SWL && guard < 40000) begin
      if (idx == rst_beat) break;
      bus.sw_valid = ($urandom_range(0, 99) >= bubble);
      bus.pel_sw   = PW'(swp[idx]);
      // Stray starts while busy must be ignored.
      if (bubble > 0) bus.start = $urandom_range(0, 1);
      beat = bus.sw_valid && bus.sw_ready;
      @(posedge clk); #1;
      if (beat) idx++;
      guard++;
    end
    bus.sw_valid = 1'b0;
    bus.start    = 1'b0;

    if (rst_beat >= 0) begin
      check_val({name, " beats_before_rst"}, idx, rst_beat);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_val({name, " busy_after_rst"}, bus.busy, 0);
      check_val({name, " sw_ready_after_rst"}, bus.sw_ready, 0);
      check_val({name, " best_sad_after_rst"}, bus.best_sad, 0);
      check_val({name, " best_x_after_rst"}, bus.best_x, 0);
      repeat (20) @(posedge clk);
      #1;
      check_val({name, " no_done"}, done_cnt - base_done, 0);
      check_val({name, " cand_valid_idle"}, bus.cand_valid, 0);
      return;
    end
    check_val({name, " sw_beats"}, idx, SWL*SWL);

    guard = 0;
    while (done_cnt == base_done && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check_val({name, " done_seen"}, done_cnt - base_done, 1);
    check_val({name, " busy_after_done"}, bus.busy, 0);
    check_val({name, " busy_during_done"}, done_busy, 1);
    repeat (3) @(posedge clk);
    #1;
    check_val({name, " done_once"}, done_cnt - base_done, 1);

    check_val({name, " strobes"}, got_q.size(), NC*NC);
    for (int k = 0; k < NC*NC && k < got_q.size(); k++) begin
      want = exp_sad[k] * 65536 + (k / NC) * 256 + (k % NC);
      check_val($sformatf("%s cand%0d", name, k), got_q[k], want);
    end
    check_val({name, " best_sad"}, done_sad, exp_best_sad);
    check_val({name, " best_x"}, done_x, exp_best_x);
    check_val({name, " best_y"}, done_y, exp_best_y);
    check_val({name, " held_best_sad"}, bus.best_sad, exp_best_sad);
    check_val({name, " held_best_x"}, bus.best_x, exp_best_x);
    check_val({name, " held_best_y"}, bus.best_y, exp_best_y);
  endtask

  task automatic plant(input int x, input int y);
    for (int j = 0; j < TBL; j++)
      for (int i = 0; i < TBL; i++) swp[(y + j)*SWL + x + i] = tbp[j*TBL + i];
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.tb_valid = 1'b0;
    bus.pel_tb   = '0;
    bus.sw_valid = 1'b0;
    bus.pel_sw   = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst busy", bus.busy, 0);
    check_val("rst done", bus.done, 0);
    check_val("rst tb_ready", bus.tb_ready, 0);
    check_val("rst sw_ready", bus.sw_ready, 0);
    check_val("rst cand_valid", bus.cand_valid, 0);
    check_val("rst cand_sad", bus.cand_sad, 0);
    check_val("rst best_sad", bus.best_sad, 0);
    check_val("rst best_x", bus.best_x, 0);
    check_val("rst best_y", bus.best_y, 0);
    repeat (2) @(posedge clk);
    #1;

    // Flat blocks: every SAD zero, first candidate wins.
    foreach (tbp[i]) tbp[i] = 8'h40;
    foreach (swp[i]) swp[i] = 8'h40;
    run_search("t1_flat", 0, -1);

    // Extreme contrast: largest possible SAD everywhere.
    foreach (tbp[i]) tbp[i] = 8'hFF;
    foreach (swp[i]) swp[i] = 8'h00;
    run_search("t3_max", 0, -1);

    // Two identical exact matches: the earlier raster position must win.
    foreach (tbp[i]) tbp[i] = $urandom_range(0, 255);
    foreach (swp[i]) swp[i] = $urandom_range(0, 255);
    plant(2, 2);
    plant(10, 4);
    run_search("t4_tie", 0, -1);
    check_val("t4 tie_x", done_x, 2);
    check_val("t4 tie_y", done_y, 2);

    // Random window, template cut from (5,3).
    foreach (swp[i]) swp[i] = $urandom_range(0, 255);
    for (int j = 0; j < TBL; j++)
      for (int i = 0; i < TBL; i++) tbp[j*TBL + i] = swp[(3 + j)*SWL + 5 + i];
    run_search("t2_rand", 0, -1);
    check_val("t2 match_x", done_x, 5);
    check_val("t2 match_y", done_y, 3);

    run_search("t5_bubbles", 50, -1);
    check_val("t5 match_x", done_x, 5);
    check_val("t5 match_y", done_y, 3);

    run_search("t6_rst", 0, 300);
    run_search("t6_rerun", 0, -1);
    check_val("t6 match_x", done_x, 5);
    check_val("t6 match_y", done_y, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
